// File: rtl/id_ex_if.sv
// Decode/execute boundary bundle for the ID/EX pipeline register.
// master: decode side and hazard logic (drives D fields and FlushE, sees E
// fields and stalls). slave: the pipeline register itself.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              FlushE;
  logic              RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, CSRWriteD;
  logic [1:0]        ResultSrcD;
  logic [3:0]        ALUControlD;
  logic [4:0]        Rs1_D, Rs2_D, RD_D;
  logic [CSR_AW-1:0] CSR_AddrD;
  logic [XLEN-1:0]   RD1_D, RD2_D, Imm_ExtD, PCD, PCPlus4D;

  logic              RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, CSRWriteE;
  logic [1:0]        ResultSrcE;
  logic [3:0]        ALUControlE;
  logic [4:0]        Rs1_E, Rs2_E, RD_E;
  logic [CSR_AW-1:0] CSR_AddrE;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E;
  logic              ValidE;
  logic              StallF, StallD;
  logic [31:0]       BubbleCount;

  modport master (
    output FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, CSRWriteD,
           ResultSrcD, ALUControlD, Rs1_D, Rs2_D, RD_D, CSR_AddrD,
           RD1_D, RD2_D, Imm_ExtD, PCD, PCPlus4D,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, CSRWriteE,
           ResultSrcE, ALUControlE, Rs1_E, Rs2_E, RD_E, CSR_AddrE,
           RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ValidE, StallF, StallD,
           BubbleCount
  );

  modport slave (
    input  FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, CSRWriteD,
           ResultSrcD, ALUControlD, Rs1_D, Rs2_D, RD_D, CSR_AddrD,
           RD1_D, RD2_D, Imm_ExtD, PCD, PCPlus4D,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, CSRWriteE,
           ResultSrcE, ALUControlE, Rs1_E, Rs2_E, RD_E, CSR_AddrE,
           RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ValidE, StallF, StallD,
           BubbleCount
  );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Captures decode outputs each cycle, inserts a bubble on flush or load-use,
// and raises the load-use stall toward fetch/decode.
// Optional build macro: ID_EX_PERF_CNT_EN enables the 32-bit bubble counter;
// without it BubbleCount is tied to zero.
module id_ex_pipeline_register #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input logic  clk,
  input logic  rst,
  id_ex_if.slave bus
);

  logic load_use;
  logic bubble;

  // Load in execute whose destination is read by the decode instruction.
  // A concurrent flush kills the dependent instruction, so no stall then.
  always_comb begin
    load_use = bus.ValidE && (bus.ResultSrcE == 2'b01) && (bus.RD_E != 5'd0) &&
               ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));
    bubble   = bus.FlushE || load_use;
  end

  assign bus.StallF = load_use && !bus.FlushE;
  assign bus.StallD = load_use && !bus.FlushE;

  // Execute-stage state: cleared on reset and on bubble, else copies decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.CSRWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.ALUControlE <= 4'd0;
      bus.Rs1_E       <= 5'd0;
      bus.Rs2_E       <= 5'd0;
      bus.RD_E        <= 5'd0;
      bus.CSR_AddrE   <= '0;
      bus.RD1_E       <= '0;
      bus.RD2_E       <= '0;
      bus.Imm_ExtE    <= '0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
      bus.ValidE      <= 1'b0;
    end else begin
      bus.RegWriteE   <= bus.RegWriteD;
      bus.MemWriteE   <= bus.MemWriteD;
      bus.JumpE       <= bus.JumpD;
      bus.BranchE     <= bus.BranchD;
      bus.ALUSrcE     <= bus.ALUSrcD;
      bus.CSRWriteE   <= bus.CSRWriteD;
      bus.ResultSrcE  <= bus.ResultSrcD;
      bus.ALUControlE <= bus.ALUControlD;
      bus.Rs1_E       <= bus.Rs1_D;
      bus.Rs2_E       <= bus.Rs2_D;
      bus.RD_E        <= bus.RD_D;
      bus.CSR_AddrE   <= bus.CSR_AddrD;
      bus.RD1_E       <= bus.RD1_D;
      bus.RD2_E       <= bus.RD2_D;
      bus.Imm_ExtE    <= bus.Imm_ExtD;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
      bus.ValidE      <= 1'b1;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_count;

  // Count bubble edges once each, whether caused by flush, load-use or both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= 32'd0;
    end else if (bubble) begin
      bubble_count <= bubble_count + 32'd1;
    end
  end

  assign bus.BubbleCount = bubble_count;
`else
  assign bus.BubbleCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register: the driver predicts stall and
// execute contents from an instruction-level model of the execute slot; the
// monitor compares them against the DUT away from the clock edges.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        reg_write, mem_write, jump, branch, alu_src, csr_write;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr_addr;
    logic [31:0] rd1, rd2, imm, pc, pc_plus4;
  } ins_t;

  typedef struct packed {
    logic        valid;
    ins_t        ins;
    logic [31:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_ex_if #(.XLEN(32), .CSR_AW(12)) bus ();

  id_ex_pipeline_register #(.XLEN(32), .CSR_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit   stall_q[$];
  exp_t e_q[$];

  // Model of the execute slot: empty, or holding one instruction.
  bit          m_valid = 1'b0;
  ins_t        m_ins   = '0;
  logic [31:0] m_count = 32'd0;

  function automatic ins_t rand_ins();
    ins_t r;
    r.reg_write   = 1'($urandom);
    r.mem_write   = 1'($urandom);
    r.jump        = 1'($urandom);
    r.branch      = 1'($urandom);
    r.alu_src     = 1'($urandom);
    r.csr_write   = 1'($urandom);
    r.result_src  = 2'($urandom);
    r.alu_control = 4'($urandom);
    r.rs1         = 5'($urandom_range(0, 7));
    r.rs2         = 5'($urandom_range(0, 7));
    r.rd          = 5'($urandom_range(0, 7));
    r.csr_addr    = 12'($urandom);
    r.rd1         = $urandom;
    r.rd2         = $urandom;
    r.imm         = $urandom;
    r.pc          = $urandom;
    r.pc_plus4    = $urandom;
    return r;
  endfunction

  task automatic apply(input ins_t d);
    bus.RegWriteD   = d.reg_write;
    bus.MemWriteD   = d.mem_write;
    bus.JumpD       = d.jump;
    bus.BranchD     = d.branch;
    bus.ALUSrcD     = d.alu_src;
    bus.CSRWriteD   = d.csr_write;
    bus.ResultSrcD  = d.result_src;
    bus.ALUControlD = d.alu_control;
    bus.Rs1_D       = d.rs1;
    bus.Rs2_D       = d.rs2;
    bus.RD_D        = d.rd;
    bus.CSR_AddrD   = d.csr_addr;
    bus.RD1_D       = d.rd1;
    bus.RD2_D       = d.rd2;
    bus.Imm_ExtD    = d.imm;
    bus.PCD         = d.pc;
    bus.PCPlus4D    = d.pc_plus4;
  endtask

  function automatic exp_t get_e();
    exp_t a;
    a.valid           = bus.ValidE;
    a.ins.reg_write   = bus.RegWriteE;
    a.ins.mem_write   = bus.MemWriteE;
    a.ins.jump        = bus.JumpE;
    a.ins.branch      = bus.BranchE;
    a.ins.alu_src     = bus.ALUSrcE;
    a.ins.csr_write   = bus.CSRWriteE;
    a.ins.result_src  = bus.ResultSrcE;
    a.ins.alu_control = bus.ALUControlE;
    a.ins.rs1         = bus.Rs1_E;
    a.ins.rs2         = bus.Rs2_E;
    a.ins.rd          = bus.RD_E;
    a.ins.csr_addr    = bus.CSR_AddrE;
    a.ins.rd1         = bus.RD1_E;
    a.ins.rd2         = bus.RD2_E;
    a.ins.imm         = bus.Imm_ExtE;
    a.ins.pc          = bus.PCE;
    a.ins.pc_plus4    = bus.PCPlus4E;
    a.count           = bus.BubbleCount;
    return a;
  endfunction

  // One decode cycle: present d at the falling edge and predict the result.
  task automatic drive(input ins_t d, input bit flush, input bit release_rst);
    bit   lu;
    exp_t e;
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    apply(d);
    bus.FlushE = flush;
    lu = m_valid && (m_ins.result_src == 2'b01) && (m_ins.rd != 5'd0) &&
         (m_ins.rd == d.rs1 || m_ins.rd == d.rs2);
    stall_q.push_back(lu && !flush);
    if (flush || lu) begin
      m_valid = 1'b0;
      m_ins   = '0;
`ifdef ID_EX_PERF_CNT_EN
      m_count = m_count + 32'd1;
`endif
    end else begin
      m_valid = 1'b1;
      m_ins   = d;
    end
    e.valid = m_valid;
    e.ins   = m_ins;
    e.count = m_count;
    e_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    exp_t a;
    a = get_e();
    checks++;
    if (a !== exp_t'(0) || bus.StallF !== 1'b0 || bus.StallD !== 1'b0) begin
      errors++;
      $display("FAIL %s got E=%h stallF=%b stallD=%b want E=0 stalls=0",
               name, a, bus.StallF, bus.StallD);
    end
  endtask

  // Monitor: stall checked mid-low-phase, execute state just after the edge.
  initial begin
    bit   es;
    exp_t ee, a;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        es = stall_q.pop_front();
        checks++;
        if (bus.StallF !== es || bus.StallD !== es) begin
          errors++;
          $display("FAIL stall got F=%b D=%b want %b at %0t", bus.StallF, bus.StallD, es, $time);
        end
      end
      @(posedge clk);
      #1;
      if (e_q.size() > 0) begin
        ee = e_q.pop_front();
        a  = get_e();
        checks++;
        if (a !== ee) begin
          errors++;
          $display("FAIL exec_state got %h want %h at %0t", a, ee, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t ld, dep, dep2, c, all1;
    all1 = '1;
    apply(all1);
    bus.FlushE = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_idle("reset_hold");

    // First capture right after reset release.
    drive(rand_ins(), 1'b0, 1'b1);

    // lw x5 followed by two dependents: exactly one bubble.
    ld = rand_ins(); ld.result_src = 2'b01; ld.rd = 5'd5;
    dep = rand_ins(); dep.rs1 = 5'd5; dep.rs2 = 5'd2; dep.result_src = 2'b00;
    dep2 = rand_ins(); dep2.rs1 = 5'd5; dep2.rs2 = 5'd5;
    drive(ld, 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    drive(dep2, 1'b0, 1'b0);

    // x0-destination load never stalls.
    ld.rd = 5'd0;
    dep = rand_ins(); dep.rs1 = 5'd3; dep.rs2 = 5'd0;
    drive(ld, 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);

    // Flush coinciding with a load-use match: no stall, single bubble.
    ld.rd = 5'd7;
    dep = rand_ins(); dep.rs2 = 5'd7;
    drive(ld, 1'b0, 1'b0);
    drive(dep, 1'b1, 1'b0);
    drive(dep, 1'b0, 1'b0);

    // CSR instruction flushed, then taken.
    c = rand_ins(); c.csr_write = 1'b1; c.csr_addr = 12'h300; c.result_src = 2'b11;
    drive(c, 1'b1, 1'b0);
    drive(c, 1'b0, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(rand_ins(), ($urandom_range(0, 7) == 0), 1'b0);
    end

    // Reset asserted while a stall is being requested.
    ld = rand_ins(); ld.result_src = 2'b01; ld.rd = 5'd4;
    dep = rand_ins(); dep.rs1 = 5'd4;
    drive(ld, 1'b0, 1'b0);
    drive(dep, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_idle("reset_mid_stall");
    e_q.delete();
    stall_q.delete();
    m_valid = 1'b0;
    m_ins   = '0;
    m_count = 32'd0;
    @(posedge clk);
    #1;
    check_idle("reset_held_edge");

    drive(dep, 1'b0, 1'b1);
    drive(rand_ins(), 1'b0, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (e_q.size() != 0 || stall_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", e_q.size(), stall_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32 core with CSR support.
- Consumes the flush request produced by the hazard/forwarding logic.
- Generates the load-use stall request that hazard/forwarding logic cannot resolve by forwarding.
- Inserts a bubble into execute on flush or load-use, otherwise captures decode outputs each cycle.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- FlushE  in  1  branch/jump flush request for execute stage.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, CSRWriteD  in  1 each  decode control bits.
- ResultSrcD  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 CSR.
- ALUControlD  in  4  ALU operation.
- Rs1_D, Rs2_D, RD_D  in  5 each  register indices.
- CSR_AddrD  in  CSR_AW  CSR address.
- RD1_D, RD2_D, Imm_ExtD, PCD, PCPlus4D  in  XLEN each  operand/immediate/PC values.
- The same signal set with suffix E  out  same widths  registered execute-stage copies.
- ValidE  out  1  execute slot holds a real instruction.
- StallF, StallD  out  1 each  load-use stall request to fetch and decode registers (combinational).
- BubbleCount  out  32  inserted-bubble count (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1): every E output, ValidE and BubbleCount = 0. ResultSrcE=00, so no load is seen. StallF/StallD therefore evaluate to 0. State holds at zero while rst stays high.
- Load-use detect (combinational): LoadUse = ValidE & (ResultSrcE==01) & (RD_E!=0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D)).
  - StallF = StallD = LoadUse & ~FlushE.
  - A simultaneous flush kills the dependent decode instruction, so no stall is raised.
- Per rising edge, priority high to low:
  1. FlushE=1: bubble. All control bits 0, ResultSrcE=00, ALUControlE=0, Rs1_E=Rs2_E=RD_E=0, CSR_AddrE=0, data fields 0, ValidE=0.
  2. LoadUse=1: bubble, identical to flush. The decode instruction is held upstream by StallD and re-presented next cycle.
  3. Otherwise: capture all D inputs into E, ValidE=1.
- Bubble guarantees:
  - Zeroed RD_E/RegWriteE keep downstream forwarding from matching.
  - Zeroed CSRWriteE/MemWriteE guarantee no architectural side effect.
- Latency: one cycle from D input to E output. A load-use stall costs exactly one bubble.
- Back-to-back: a load followed by a dependent instruction, followed by another dependent instruction, stalls only once. After the bubble ValidE=0 and the load sits in memory stage, where forwarding covers it.
- x0 destination load never stalls.
- Reset asserted mid-stall immediately clears E state, and StallF/StallD fall to 0 in the same cycle.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: BubbleCount is a 32-bit counter.
  - Increments by 1 on each edge where a bubble is inserted (flush or load-use, counted once if both).
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst.
- Undefined: BubbleCount tied to 0 and no counter flops are generated.

Test Plan:
- Reset with all D inputs nonzero → all E outputs 0, ValidE=0, StallF=StallD=0; deassert rst, next edge E equals D with ValidE=1.
- Load lw x5 (RD_E=5, ResultSrcE=01, ValidE=1), decode Rs1_D=5 → StallF=StallD=1 in same cycle; next edge ValidE=0, RD_E=0, RegWriteE=0; following edge captures the dependent instruction, stall 0.
- Load with RD_E=0 and Rs2_D=0 → no stall, capture normally.
- FlushE=1 concurrently with a load-use match → StallF=StallD=0; next edge yields a bubble; BubbleCount increments by exactly 1 (macro defined).
- CSR instruction (CSRWriteD=1, CSR_AddrD=0x300, ResultSrcD=11) with FlushE=1 → CSRWriteE=0, CSR_AddrE=0 next edge; with FlushE=0 → CSRWriteE=1, CSR_AddrE=0x300.
- ID_EX_PERF_CNT_EN defined: preload 0xFFFFFFFF through the counter, insert one bubble → BubbleCount=0; macro undefined → BubbleCount stays 0 through 10 bubbles.
